vote_result_tx: RTL and testbench

VOTE_RESULT_TX -- requirements
Module: vote_result_tx

---
 rtl/vote_result_tx.sv | 173 +++++++++++++++++
 tb/tb_vote_result_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vote_result_tx.sv
// Serialises a snapshot of four vote tallies and their winner as a UART 8N1 frame.
// Optional macro VOTE_TX_CHECKSUM_EN appends an XOR checksum byte to the frame.
module vote_result_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       send_req,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
`ifdef VOTE_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd6;
`else
  localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

  state_t      state, state_next;
  logic [15:0] clk_cnt, cnt_next;
  logic [2:0]  bit_idx, bit_next;
  logic [2:0]  byte_idx, byte_next;
  logic        done_next;
  logic        load;
  logic        bit_end;
  logic [7:0]  snap1, snap2, snap3, snap4, snap_win;
  logic [7:0]  win_live, max_live;
  logic [7:0]  cur_byte;
`ifdef VOTE_TX_CHECKSUM_EN
  logic [7:0]  snap_chk;
`endif

  // Strict greater-than keeps the lowest index on ties; all-zero leaves 0.
  always_comb begin
    win_live = 8'd0;
    max_live = 8'd0;
    if (cand1_vote > max_live) begin win_live = 8'd1; max_live = cand1_vote; end
    if (cand2_vote > max_live) begin win_live = 8'd2; max_live = cand2_vote; end
    if (cand3_vote > max_live) begin win_live = 8'd3; max_live = cand3_vote; end
    if (cand4_vote > max_live) begin win_live = 8'd4; max_live = cand4_vote; end
  end

  assign bit_end = (clk_cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        // Gating on done rejects a request landing in the completion cycle.
        if (mode && send_req && !done) begin
          load       = 1'b1;
          state_next = START;
          cnt_next   = 16'd0;
          bit_next   = 3'd0;
          byte_next  = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = 16'd0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = 16'd0;
          if (byte_idx == LAST_BYTE) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            byte_next  = byte_idx + 3'd1;
            state_next = START;
          end
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      clk_cnt  <= cnt_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      done     <= done_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap1    <= 8'd0;
      snap2    <= 8'd0;
      snap3    <= 8'd0;
      snap4    <= 8'd0;
      snap_win <= 8'd0;
`ifdef VOTE_TX_CHECKSUM_EN
      snap_chk <= 8'd0;
`endif
    end else if (load) begin
      snap1    <= cand1_vote;
      snap2    <= cand2_vote;
      snap3    <= cand3_vote;
      snap4    <= cand4_vote;
      snap_win <= win_live;
`ifdef VOTE_TX_CHECKSUM_EN
      snap_chk <= 8'hA5 ^ cand1_vote ^ cand2_vote ^ cand3_vote ^ cand4_vote ^ win_live;
`endif
    end
  end

  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      3'd1: cur_byte = snap1;
      3'd2: cur_byte = snap2;
      3'd3: cur_byte = snap3;
      3'd4: cur_byte = snap4;
      3'd5: cur_byte = snap_win;
`ifdef VOTE_TX_CHECKSUM_EN
      3'd6: cur_byte = snap_chk;
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  // tx is decoded from state so reset forces the line high without a clock edge.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vote_result_tx.sv
// Bench for vote_result_tx: directed steps, expected frame bytes queued at request time.
module tb_vote_result_tx;

  localparam int CPB = 4;
`ifdef VOTE_TX_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       send_req;
  logic [7:0] c1, c2, c3, c4;
  logic       tx, busy, done;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];

  vote_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .send_req(send_req),
    .cand1_vote(c1),
    .cand2_vote(c2),
    .cand3_vote(c3),
    .cand4_vote(c4),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    logic [7:0] t[4];
    logic [7:0] mx;
    logic [7:0] w;
    t  = '{a, b, c, d};
    mx = 8'd0;
    w  = 8'd0;
    foreach (t[i]) if (t[i] > mx) mx = t[i];
    if (mx != 8'd0) begin
      for (int i = 3; i >= 0; i--) if (t[i] == mx) w = 8'(i + 1);
    end
    sb.push_back(8'hA5);
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(c);
    sb.push_back(d);
    sb.push_back(w);
`ifdef VOTE_TX_CHECKSUM_EN
    sb.push_back(8'hA5 ^ a ^ b ^ c ^ d ^ w);
`endif
  endtask

  // Called at a negedge; returns just after the edge that sees the request.
  task automatic applyStimulus(input logic m, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input bit expectAccept);
    mode = m;
    c1 = a; c2 = b; c3 = c; c4 = d;
    send_req = 1'b1;
    if (expectAccept) pushFrame(a, b, c, d);
    @(posedge clock);
    #1 send_req = 1'b0;
  endtask

  task automatic receiveFrame();
    int         busyErr = 0;
    int         doneErr = 0;
    logic [9:0] bits = '0;
    logic [7:0] exp;
    for (int c = 0; c < NB * 10 * CPB; c++) begin
      @(negedge clock);
      if (busy !== 1'b1) busyErr++;
      if (done !== 1'b0) doneErr++;
      if (c % CPB == 1) bits[(c / CPB) % 10] = tx;
      if (c % (10 * CPB) == 10 * CPB - 1) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checkOutput($sformatf("byte%0d", c / (10 * CPB)), {24'd0, bits[8:1]}, {24'd0, exp});
        checkOutput("framing", {30'd0, bits[9], bits[0]}, 32'd2);
      end
    end
    checkOutput("busyDuringFrame", busyErr, 0);
    checkOutput("doneDuringFrame", doneErr, 0);
    @(negedge clock);
    checkOutput("doneEnd", {31'd0, done}, 1);
    checkOutput("busyEnd", {31'd0, busy}, 0);
    checkOutput("txIdleEnd", {31'd0, tx}, 1);
  endtask

  task automatic afterDone(input bit reqInDone);
    mode = 1'b1;
    send_req = reqInDone;
    @(posedge clock);
    #1 send_req = 1'b0;
    @(negedge clock);
    checkOutput("donePulseOnce", {31'd0, done}, 0);
    checkOutput("reqInDoneIgnored", {31'd0, busy}, 0);
  endtask

  initial begin
    int idleErr;
    reset = 1'b1;
    mode = 1'b0;
    send_req = 1'b0;
    c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
    #1;
    checkOutput("resetTx", {31'd0, tx}, 1);
    checkOutput("resetBusy", {31'd0, busy}, 0);
    checkOutput("resetDone", {31'd0, done}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic frame with a request while busy");
    applyStimulus(1'b1, 8'd3, 8'd7, 8'd7, 8'd1, 1'b1);
    fork
      receiveFrame();
      begin
        repeat (50) @(negedge clock);
        send_req = 1'b1;
        @(posedge clock);
        #1 send_req = 1'b0;
      end
    join
    afterDone(1'b1);

    $display("[TB] all-zero tallies, requested one cycle after done");
    applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    receiveFrame();
    afterDone(1'b0);

    $display("[TB] request in voting mode");
    applyStimulus(1'b0, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    idleErr = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idleErr++;
    end
    checkOutput("votingModeIdle", idleErr, 0);

    $display("[TB] tallies and mode change mid-frame");
    applyStimulus(1'b1, 8'd10, 8'd20, 8'd30, 8'd200, 1'b1);
    fork
      receiveFrame();
      begin
        repeat (30) @(negedge clock);
        mode = 1'b0;
        c1 = 8'd255; c2 = 8'd255; c3 = 8'd255; c4 = 8'd255;
      end
    join
    afterDone(1'b0);

    $display("[TB] reset during byte 3");
    applyStimulus(1'b1, 8'd5, 8'd9, 8'd0, 8'd2, 1'b1);
    repeat (130) @(negedge clock);
    checkOutput("txBeforeReset", {31'd0, tx}, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncResetTx", {31'd0, tx}, 1);
    checkOutput("asyncResetBusy", {31'd0, busy}, 0);
    checkOutput("asyncResetDone", {31'd0, done}, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idleAfterReset", {31'd0, busy}, 0);

    $display("[TB] frames after reset");
    applyStimulus(1'b1, 8'd9, 8'd9, 8'd4, 8'd9, 1'b1);
    receiveFrame();
    afterDone(1'b0);
    applyStimulus(1'b1, 8'd200, 8'd100, 8'd250, 8'd250, 1'b1);
    receiveFrame();
    afterDone(1'b0);

    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
